// File: rtl/rm_pkg.sv
// rtl/rm_pkg.sv - shared types and constants for the simple RISC machine
package rm_pkg;

    localparam int ADDR_W_DEF     = 9;
    localparam int DATA_W_DEF     = 16;
    localparam int LEDR_BREAK_BIT = 8;

    // Opcode field is ir[15:13]
    localparam logic [2:0] OPC_BRANCH = 3'b001;
    localparam logic [2:0] OPC_BL     = 3'b010;
    localparam logic [2:0] OPC_LDR    = 3'b011;
    localparam logic [2:0] OPC_STR    = 3'b100;
    localparam logic [2:0] OPC_ALU    = 3'b101;
    localparam logic [2:0] OPC_MOV    = 3'b110;
    localparam logic [2:0] OPC_HALT   = 3'b111;

    typedef enum logic [2:0] {
        IDLE,
        IF1,
        IF2,
        VALID,
        HALT
    } fetch_state_t;

    typedef enum logic [2:0] {
        CTRL_WAIT,
        CTRL_DECODE,
        CTRL_EXEC,
        CTRL_MEM,
        CTRL_WB
    } ctrl_state_t;

endpackage

// File: rtl/sat_counter16.sv
// rtl/sat_counter16.sv - 16-bit up counter that sticks at its maximum value
module sat_counter16 (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        en,
    output logic [15:0] count
);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (en && (count != 16'hFFFF)) begin
            count <= count + 16'd1;
        end
    end

endmodule

// File: rtl/cpu_fetch_unit.sv
// rtl/cpu_fetch_unit.sv - instruction fetch stage: PC, RAM read, IR capture, redirect and HALT
module cpu_fetch_unit
    import rm_pkg::*;
#(
    parameter int                ADDR_W   = ADDR_W_DEF,
    parameter int                DATA_W   = DATA_W_DEF,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter logic [2:0]        HALT_OPC = OPC_HALT
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              fetch_req,
    input  logic              mem_busy,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    input  logic              instr_ack,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_read,
    output logic [DATA_W-1:0] ir,
    output logic              instr_valid,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pc_link,
    output logic              halted,
    output logic [15:0]       fetch_count
);

    fetch_state_t      state;
    fetch_state_t      state_next;
    logic [ADDR_W-1:0] addr_hold;
    logic [ADDR_W-1:0] pc_inc;
    logic              capture;

    assign pc_inc  = pc + ADDR_W'(1);
    assign capture = (state == IF2);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (!redirect_valid && fetch_req && !halted) state_next = IF1;
            IF1: begin
                if (redirect_valid)  state_next = IDLE;
                else if (!mem_busy)  state_next = IF2;
            end
            IF2:     state_next = VALID;
            VALID:   if (instr_ack) state_next = halted ? HALT : IDLE;
            HALT:    state_next = HALT;
            default: state_next = IDLE;
        endcase
    end

    // Outside IF1 the address bus keeps the last fetch address so the RAM mux sees no glitch.
    always_comb begin
        mem_read    = 1'b0;
        instr_valid = 1'b0;
        mem_addr    = addr_hold;
        case (state)
            IF1: begin
                mem_addr = pc;
                mem_read = !mem_busy && !redirect_valid;
            end
            VALID:   instr_valid = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc        <= RESET_PC;
            ir        <= '0;
            pc_link   <= '0;
            halted    <= 1'b0;
            addr_hold <= '0;
        end else begin
            if (state == IF1) begin
                addr_hold <= pc;
            end
            case (state)
                IDLE, IF1, VALID: begin
                    if (redirect_valid) pc <= redirect_pc;
                end
                IF2: begin
                    ir      <= mem_rdata;
                    pc_link <= pc_inc;
                    pc      <= pc_inc;
                    if (mem_rdata[DATA_W-1 -: 3] == HALT_OPC) halted <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    sat_counter16 u_fetch_count (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (capture),
        .count   (fetch_count)
    );

endmodule

// File: tb/tb_cpu_fetch_unit.sv
// tb/tb_cpu_fetch_unit.sv - self-checking bench for cpu_fetch_unit against a transaction-level model
module tb_cpu_fetch_unit;
    import rm_pkg::*;

    localparam int AW = 9;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          fetch_req = 1'b0;
    logic          mem_busy = 1'b0;
    logic [DW-1:0] mem_rdata = '0;
    logic          redirect_valid = 1'b0;
    logic [AW-1:0] redirect_pc = '0;
    logic          instr_ack = 1'b0;
    logic [AW-1:0] mem_addr;
    logic          mem_read;
    logic [DW-1:0] ir;
    logic          instr_valid;
    logic [AW-1:0] pc;
    logic [AW-1:0] pc_link;
    logic          halted;
    logic [15:0]   fetch_count;

    int n_cmp = 0;
    int n_bad = 0;

    logic [DW-1:0] mem [0:511];
    int            m_pc;
    int            m_count;

    cpu_fetch_unit dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .fetch_req      (fetch_req),
        .mem_busy       (mem_busy),
        .mem_rdata      (mem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr_ack      (instr_ack),
        .mem_addr       (mem_addr),
        .mem_read       (mem_read),
        .ir             (ir),
        .instr_valid    (instr_valid),
        .pc             (pc),
        .pc_link        (pc_link),
        .halted         (halted),
        .fetch_count    (fetch_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_read) mem_rdata <= mem[mem_addr];
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Request one fetch, stall IF1 for `busy` cycles, return latency and observed reads.
    task automatic do_fetch(input int busy, output int lat, output int reads, output logic [AW-1:0] rd_addr);
        lat = -1; reads = 0; rd_addr = '0;
        fetch_req = 1'b1; mem_busy = 1'b0;
        for (int c = 1; c <= 60 && lat < 0; c++) begin
            @(posedge clk); #1;
            fetch_req = 1'b0;
            mem_busy  = (c <= busy);
            @(negedge clk);
            if (mem_read) begin reads++; rd_addr = mem_addr; end
            if (instr_valid) lat = c;
        end
        mem_busy = 1'b0;
    endtask

    task automatic do_ack(input logic redir, input logic [AW-1:0] tgt);
        instr_ack = 1'b1; redirect_valid = redir; redirect_pc = tgt;
        @(posedge clk); #1;
        instr_ack = 1'b0; redirect_valid = 1'b0;
    endtask

    task automatic idle_redirect(input logic [AW-1:0] tgt);
        redirect_valid = 1'b1; redirect_pc = tgt;
        @(posedge clk); #1;
        redirect_valid = 1'b0;
        m_pc = tgt;
    endtask

    task automatic test_reset;
        reset_n = 1'b0; fetch_req = 1'b1; redirect_valid = 1'b1; redirect_pc = 9'h055;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_cmp++; if (pc !== 9'd0)        begin n_bad++; $display("FAIL rst_pc: got %h expected 0", pc); end
        n_cmp++; if (ir !== 16'd0)       begin n_bad++; $display("FAIL rst_ir: got %h expected 0", ir); end
        n_cmp++; if (pc_link !== 9'd0)   begin n_bad++; $display("FAIL rst_pc_link: got %h expected 0", pc_link); end
        n_cmp++; if (fetch_count !== 16'd0) begin n_bad++; $display("FAIL rst_count: got %h expected 0", fetch_count); end
        n_cmp++; if (instr_valid !== 1'b0)  begin n_bad++; $display("FAIL rst_valid: got %b expected 0", instr_valid); end
        n_cmp++; if (mem_read !== 1'b0)  begin n_bad++; $display("FAIL rst_mem_read: got %b expected 0", mem_read); end
        n_cmp++; if (mem_addr !== 9'd0)  begin n_bad++; $display("FAIL rst_mem_addr: got %h expected 0", mem_addr); end
        n_cmp++; if (halted !== 1'b0)    begin n_bad++; $display("FAIL rst_halted: got %b expected 0", halted); end
        fetch_req = 1'b0; redirect_valid = 1'b0;
        reset_n = 1'b1;
        m_pc = 0; m_count = 0;
    endtask

    task automatic test_sequential;
        int lat, rd; logic [AW-1:0] ra;
        mem[0] = 16'hD105; mem[1] = 16'hD20A;
        do_fetch(0, lat, rd, ra);
        n_cmp++; if (lat != 3)          begin n_bad++; $display("FAIL seq_latency: got %0d expected 3", lat); end
        n_cmp++; if (rd != 1 || ra !== 9'd0) begin n_bad++; $display("FAIL seq_read0: got %0d reads at %h expected 1 at 0", rd, ra); end
        n_cmp++; if (ir !== 16'hD105)   begin n_bad++; $display("FAIL seq_ir0: got %h expected D105", ir); end
        n_cmp++; if (pc !== 9'd1 || pc_link !== 9'd1) begin n_bad++; $display("FAIL seq_pc0: got pc %h link %h expected 1 1", pc, pc_link); end
        do_ack(1'b0, '0);
        do_fetch(0, lat, rd, ra);
        n_cmp++; if (ir !== 16'hD20A)   begin n_bad++; $display("FAIL seq_ir1: got %h expected D20A", ir); end
        n_cmp++; if (pc !== 9'd2 || pc_link !== 9'd2) begin n_bad++; $display("FAIL seq_pc1: got pc %h link %h expected 2 2", pc, pc_link); end
        n_cmp++; if (fetch_count !== 16'd2) begin n_bad++; $display("FAIL seq_count: got %0d expected 2", fetch_count); end
        do_ack(1'b0, '0);
        m_pc = 2; m_count = 2;
    endtask

    task automatic test_contention;
        int lat, rd; logic [AW-1:0] ra;
        do_fetch(2, lat, rd, ra);
        m_count++;
        n_cmp++; if (lat != 5) begin n_bad++; $display("FAIL busy_latency: got %0d expected 5", lat); end
        n_cmp++; if (rd != 1 || ra !== 9'(m_pc)) begin n_bad++; $display("FAIL busy_reads: got %0d reads at %h expected 1 at %h", rd, ra, 9'(m_pc)); end
        n_cmp++; if (ir !== mem[m_pc]) begin n_bad++; $display("FAIL busy_ir: got %h expected %h", ir, mem[m_pc]); end
        do_ack(1'b0, '0);
        m_pc = m_pc + 1;
    endtask

    task automatic test_redirect;
        int lat, rd; logic [AW-1:0] ra;
        do_fetch(0, lat, rd, ra);
        m_count++; m_pc = m_pc + 1;
        n_cmp++; if (pc !== 9'd4) begin n_bad++; $display("FAIL redir_pc_before: got %h expected 4", pc); end
        redirect_valid = 1'b1; redirect_pc = 9'd100;
        @(posedge clk); #1;
        redirect_valid = 1'b0;
        n_cmp++; if (pc !== 9'd100 || instr_valid !== 1'b1) begin n_bad++; $display("FAIL redir_noack: got pc %h valid %b expected 064 1", pc, instr_valid); end
        do_ack(1'b1, 9'd25);
        n_cmp++; if (pc !== 9'd25 || instr_valid !== 1'b0) begin n_bad++; $display("FAIL redir_ack: got pc %h valid %b expected 019 0", pc, instr_valid); end
        do_fetch(0, lat, rd, ra);
        m_count++;
        n_cmp++; if (ra !== 9'd25 || ir !== mem[25]) begin n_bad++; $display("FAIL redir_fetch: got addr %h ir %h expected 019 %h", ra, ir, mem[25]); end
        n_cmp++; if (pc !== 9'd26) begin n_bad++; $display("FAIL redir_pc_after: got %h expected 01a", pc); end
        do_ack(1'b0, '0);
        m_pc = 26;
    endtask

    task automatic test_redirect_if1;
        logic [AW-1:0] tgt;
        logic          leak;
        int lat, rd; logic [AW-1:0] ra;
        tgt = 9'($urandom);
        leak = 1'b0;
        fetch_req = 1'b1;
        @(posedge clk); #1;
        fetch_req = 1'b0; redirect_valid = 1'b1; redirect_pc = tgt;
        @(negedge clk);
        n_cmp++; if (mem_read !== 1'b0) begin n_bad++; $display("FAIL if1_abort_read: got %b expected 0", mem_read); end
        @(posedge clk); #1;
        redirect_valid = 1'b0;
        n_cmp++; if (pc !== tgt) begin n_bad++; $display("FAIL if1_abort_pc: got %h expected %h", pc, tgt); end
        repeat (4) begin
            @(negedge clk);
            if (instr_valid !== 1'b0 || mem_read !== 1'b0) leak = 1'b1;
        end
        n_cmp++; if (leak !== 1'b0) begin n_bad++; $display("FAIL if1_abort_quiet: got activity %b expected 0", leak); end
        n_cmp++; if (fetch_count !== 16'(m_count)) begin n_bad++; $display("FAIL if1_abort_count: got %0d expected %0d", fetch_count, m_count); end
        m_pc = tgt;
        do_fetch(0, lat, rd, ra);
        m_count++;
        n_cmp++; if (ra !== tgt) begin n_bad++; $display("FAIL if1_refetch: got addr %h expected %h", ra, tgt); end
        do_ack(1'b0, '0);
        m_pc = (m_pc + 1) % 512;
    endtask

    task automatic test_random;
        int lat, rd; logic [AW-1:0] ra;
        logic [AW-1:0] t;
        logic [DW-1:0] exp_ir;
        int exp_next;
        for (int it = 0; it < 25; it++) begin
            int busy;
            busy = $urandom_range(0, 3);
            if ($urandom_range(0, 1) == 1) begin
                t = 9'($urandom);
                fetch_req = 1'b1;
                idle_redirect(t);
                fetch_req = 1'b0;
            end
            exp_ir = mem[m_pc];
            exp_next = (m_pc + 1) % 512;
            do_fetch(busy, lat, rd, ra);
            m_count++;
            n_cmp++; if (lat != busy + 3) begin n_bad++; $display("FAIL rnd%0d_latency: got %0d expected %0d", it, lat, busy + 3); end
            n_cmp++; if (rd != 1 || ra !== 9'(m_pc)) begin n_bad++; $display("FAIL rnd%0d_read: got %0d at %h expected 1 at %h", it, rd, ra, 9'(m_pc)); end
            n_cmp++; if (ir !== exp_ir) begin n_bad++; $display("FAIL rnd%0d_ir: got %h expected %h", it, ir, exp_ir); end
            n_cmp++; if (pc !== 9'(exp_next) || pc_link !== 9'(exp_next)) begin n_bad++; $display("FAIL rnd%0d_pc: got %h/%h expected %h", it, pc, pc_link, 9'(exp_next)); end
            n_cmp++; if (fetch_count !== 16'(m_count)) begin n_bad++; $display("FAIL rnd%0d_count: got %0d expected %0d", it, fetch_count, m_count); end
            m_pc = exp_next;
            t = 9'($urandom);
            if ($urandom_range(0, 3) == 0) begin
                do_ack(1'b1, t);
                m_pc = t;
            end else begin
                do_ack(1'b0, t);
            end
            n_cmp++; if (pc !== 9'(m_pc) || instr_valid !== 1'b0) begin n_bad++; $display("FAIL rnd%0d_ack: got pc %h valid %b expected %h 0", it, pc, instr_valid, 9'(m_pc)); end
        end
    endtask

    task automatic test_wrap;
        int lat, rd; logic [AW-1:0] ra;
        idle_redirect(9'h1FF);
        do_fetch(0, lat, rd, ra);
        m_count++;
        n_cmp++; if (ra !== 9'h1FF || ir !== mem[511]) begin n_bad++; $display("FAIL wrap_fetch: got addr %h ir %h expected 1ff %h", ra, ir, mem[511]); end
        n_cmp++; if (pc !== 9'd0 || pc_link !== 9'd0) begin n_bad++; $display("FAIL wrap_pc: got pc %h link %h expected 0 0", pc, pc_link); end
        do_ack(1'b0, '0);
        m_pc = 0;
    endtask

    task automatic test_halt;
        int lat, rd; logic [AW-1:0] ra;
        int reads, valids;
        mem[3] = 16'hE000;
        idle_redirect(9'd3);
        n_cmp++; if (halted !== 1'b0) begin n_bad++; $display("FAIL halt_pre: got %b expected 0", halted); end
        do_fetch(0, lat, rd, ra);
        m_count++;
        n_cmp++; if (ir !== 16'hE000 || halted !== 1'b1) begin n_bad++; $display("FAIL halt_capture: got ir %h halted %b expected E000 1", ir, halted); end
        do_ack(1'b0, '0);
        reads = 0; valids = 0;
        fetch_req = 1'b1; redirect_valid = 1'b1; redirect_pc = 9'h040;
        repeat (20) begin
            @(negedge clk);
            if (mem_read) reads++;
            if (instr_valid) valids++;
        end
        fetch_req = 1'b0; redirect_valid = 1'b0;
        n_cmp++; if (reads != 0 || valids != 0) begin n_bad++; $display("FAIL halt_quiet: got %0d reads %0d valids expected 0 0", reads, valids); end
        n_cmp++; if (pc !== 9'd4 || halted !== 1'b1) begin n_bad++; $display("FAIL halt_hold: got pc %h halted %b expected 004 1", pc, halted); end
        n_cmp++; if (fetch_count !== 16'(m_count)) begin n_bad++; $display("FAIL halt_count: got %0d expected %0d", fetch_count, m_count); end
    endtask

    task automatic test_reset_mid_if2;
        @(negedge clk); reset_n = 1'b0;
        @(negedge clk); reset_n = 1'b1;
        fetch_req = 1'b1;
        @(posedge clk); #1;
        fetch_req = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b0;
        #1;
        n_cmp++; if (pc !== 9'd0 || pc_link !== 9'd0 || ir !== 16'd0) begin n_bad++; $display("FAIL mid_rst_regs: got pc %h link %h ir %h expected 0 0 0", pc, pc_link, ir); end
        n_cmp++; if (instr_valid !== 1'b0 || mem_read !== 1'b0 || mem_addr !== 9'd0 || halted !== 1'b0) begin n_bad++; $display("FAIL mid_rst_ctrl: got valid %b read %b addr %h halted %b expected 0 0 0 0", instr_valid, mem_read, mem_addr, halted); end
        n_cmp++; if (fetch_count !== 16'd0) begin n_bad++; $display("FAIL mid_rst_count: got %0d expected 0", fetch_count); end
        @(negedge clk); reset_n = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++; if (fetch_count !== 16'd0 || instr_valid !== 1'b0) begin n_bad++; $display("FAIL mid_rst_after: got count %0d valid %b expected 0 0", fetch_count, instr_valid); end
    endtask

    initial begin
        for (int i = 0; i < 512; i++) mem[i] = 16'($urandom) & 16'hDFFF;
        test_reset();
        test_sequential();
        test_contention();
        test_redirect();
        test_redirect_if1();
        test_random();
        test_wrap();
        test_halt();
        test_reset_mid_if2();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
